// File: rtl/family_selector_if.sv
// Bundle between the family bus producer and the selector. The producer drives
// start and family; the selector returns the winning genome, its index and its cost.
interface family_selector_if #(
  parameter int N_MEMBERS = 5,
  parameter int GENES     = 30,
  parameter int GENE_W    = 5,
  parameter int COST_W    = 10
);
  logic                                  start;
  logic [N_MEMBERS*GENES*GENE_W-1:0]     family;
  logic [GENES*GENE_W-1:0]               parent_out;
  logic [$clog2(N_MEMBERS)-1:0]          best_index;
  logic [COST_W-1:0]                     best_cost;
  logic                                  done;

  modport master (
    output start, family,
    input  parent_out, best_index, best_cost, done
  );

  modport slave (
    input  start, family,
    output parent_out, best_index, best_cost, done
  );
endinterface

// File: rtl/family_selector.sv
// Serially scores each captured genome by the summed absolute step between adjacent
// genes and reports the lowest-cost member. Ties keep the lower index.
module family_selector #(
  parameter int N_MEMBERS = 5,
  parameter int GENES     = 30,
  parameter int GENE_W    = 5,
  parameter int COST_W    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  family_selector_if.slave bus
);
  localparam int G_W    = GENES * GENE_W;
  localparam int F_W    = N_MEMBERS * G_W;
  localparam int MIDX_W = $clog2(N_MEMBERS);
  localparam int GIDX_W = $clog2(GENES);
  localparam logic [GIDX_W-1:0] LAST_PAIR   = GIDX_W'(GENES - 2);
  localparam logic [MIDX_W-1:0] LAST_MEMBER = MIDX_W'(N_MEMBERS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;

  state_t              state_reg, state_next;
  logic [F_W-1:0]      fam_reg;
  logic [MIDX_W-1:0]   member_reg;
  logic [GIDX_W-1:0]   gene_reg;
  logic [COST_W-1:0]   acc_reg;
  logic [G_W-1:0]      parent_reg;
  logic [MIDX_W-1:0]   best_index_reg;
  logic [COST_W-1:0]   best_cost_reg;
  logic                done_reg;

  logic [G_W-1:0]      members [N_MEMBERS];
  logic [GENE_W-1:0]   genes   [GENES];
  logic [G_W-1:0]      cur;
  logic [GIDX_W-1:0]   gene_hi_idx;
  logic [GENE_W:0]     diff;
  logic [GENE_W-1:0]   abs_diff;
  logic                accept;
  logic                take;

  genvar gi;
  generate
    for (gi = 0; gi < N_MEMBERS; gi++) begin : g_members
      assign members[gi] = fam_reg[gi*G_W +: G_W];
    end
    for (gi = 0; gi < GENES; gi++) begin : g_genes
      assign genes[gi] = cur[gi*GENE_W +: GENE_W];
    end
  endgenerate

  assign cur         = members[member_reg];
  assign gene_hi_idx = gene_reg + 1'b1;
  assign diff        = {1'b0, genes[gene_hi_idx]} - {1'b0, genes[gene_reg]};
  assign abs_diff    = diff[GENE_W] ? GENE_W'(-diff) : diff[GENE_W-1:0];

  // The cycle carrying the done pulse is treated as part of completion, so a held
  // start re-triggers only after it.
  assign accept = (state_reg == IDLE) && bus.start && !done_reg;
  assign take   = (member_reg == '0) || (acc_reg < best_cost_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EVAL;
      EVAL: if (gene_reg == LAST_PAIR) state_next = CMP;
      CMP:  state_next = (member_reg == LAST_MEMBER) ? DONE : EVAL;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fam_reg        <= '0;
      member_reg     <= '0;
      gene_reg       <= '0;
      acc_reg        <= '0;
      parent_reg     <= '0;
      best_index_reg <= '0;
      best_cost_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            fam_reg    <= bus.family;
            member_reg <= '0;
            gene_reg   <= '0;
            acc_reg    <= '0;
          end
        end
        EVAL: begin
          acc_reg  <= acc_reg + COST_W'(abs_diff);
          gene_reg <= gene_reg + 1'b1;
        end
        CMP: begin
          if (take) begin
            best_cost_reg  <= acc_reg;
            best_index_reg <= member_reg;
            parent_reg     <= cur;
          end
          if (member_reg != LAST_MEMBER) begin
            member_reg <= member_reg + 1'b1;
            gene_reg   <= '0;
            acc_reg    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.parent_out = parent_reg;
  assign bus.best_index = best_index_reg;
  assign bus.best_cost  = best_cost_reg;
  assign bus.done       = done_reg;
endmodule

// File: doc/family_selector.md
Name: family_selector

Overview:
- Consumer end of the 750-bit family bus: takes the five-member family and selects the fittest member as the next parent.
- Member 0 is the unmutated parent; members 1-4 are mutants.
- Scores each 150-bit genome serially with a path-length cost and returns the lowest-cost member, its index and its cost, via a start/done handshake.
- Closes the generation loop: its parent_out feeds the family generator's parent input for the next generation.

Parameters:
- N_MEMBERS, 5, number of genomes on the family bus.
- GENES, 30, genes per genome.
- GENE_W, 5, bits per gene (unsigned position value 0..31).
- COST_W, 10, cost accumulator width; must hold (GENES-1)*(2^GENE_W-1) = 899.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a selection; sampled only in IDLE.
- family  in  750  member m = family[150m+149:150m]; gene k of a member = bits [5k+4:5k].
- parent_out  out  150  winning genome.
- best_index  out  3  index 0..4 of the winner.
- best_cost  out  10  cost of the winner.
- done  out  1  one-cycle pulse: outputs valid and selection complete.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, the block enters IDLE. parent_out=0, best_index=0, best_cost=0, done=0, and all internal counters and the accumulator are cleared. Reset wins over every other event, including mid-EVAL; any selection in progress is abandoned with no done pulse.
- Cost function: cost(member) = sum over k=0..28 of |gene[k+1] - gene[k]|.
  - Each difference is computed unsigned on 6 bits; the absolute value is 0..31.
  - The accumulator is COST_W bits. It cannot overflow; the maximum is 899.
- FSM states: IDLE, EVAL, CMP, DONE.
- IDLE:
  - Holds all outputs; done=0.
  - On start=1: capture family into an internal 750-bit register, set member=0, gene=0, acc=0, then go to EVAL.
  - Family changes after capture have no effect.
- EVAL:
  - One gene pair per cycle: acc += |g[gene+1] - g[gene]| of the captured member, then gene++.
  - After the pair with gene=28 is added (29 cycles), go to CMP.
- CMP (one cycle):
  - If member==0, or acc < best register (strict), load best_cost=acc, best_index=member and parent_out=captured member.
  - Ties keep the lower index, so the parent survives ties.
  - Then, if member==4, go to DONE. Otherwise member++, gene=0, acc=0, and return to EVAL.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Output timing:
  - parent_out, best_index and best_cost update only in CMP. Intermediate winners are therefore visible during a run; consumers must use them only when done=1.
  - Outputs hold their last values in IDLE until the next run's first CMP.
- Latency: with start sampled at edge E0, done is high during the cycle following edge E0+151 (5 x 30 = 150 cycles of EVAL/CMP, then DONE).
- start is ignored in EVAL, CMP and DONE; there is no queuing. start held high continuously re-triggers on the first IDLE cycle after DONE, i.e. back-to-back runs with one IDLE cycle between them.

Test Plan:
- Reset, then all-zero family, start pulse: done pulses exactly 151 cycles after the start edge, and only once. best_cost=0, best_index=0, parent_out=0.
- Costs 899, 29, 29, 0, 899, where 899 = genes alternating 0,31 and 29 = genes 0,1,...,29. Expected: best_index=3, best_cost=0, parent_out=member 3.
- Tie: member 0 has cost 29 (ascending), members 1-4 have cost 29 (descending 29..0) or higher. Expected: best_index=0, best_cost=29.
- Capture check: start, then overwrite family with all-zero one cycle later, with the captured member 2 being the only low-cost one. Expected: result reflects the captured family (best_index=2).
- Reset mid-run: drive rst_n=0 at cycle 70 after start. Expected: no done pulse, outputs zero, state IDLE. A fresh start then completes normally in 151 cycles.
- start held high for 400 cycles: done pulses at 151 and 304 (one IDLE cycle between runs), with identical results both times.
